// File: rtl/ledpanel_wr_arb.sv
// LED panel video-memory write arbiter: CPU pixel/register bus plus a hardware
// rectangle-free linear fill engine sharing one pixel write port.
module ledpanel_wr_arb #(
    parameter int unsigned SIZE = 1,
    localparam int unsigned PW  = 10 + $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ctrl_wr,
    input  logic          ctrl_rd,
    input  logic [15:0]   ctrl_addr,
    input  logic [31:0]   ctrl_wdat,
    output logic [31:0]   ctrl_rdat,
    output logic          ctrl_done,
    output logic          mem_wr,
    output logic [PW-1:0] mem_addr,
    output logic [23:0]   mem_wdat,
    output logic          fill_irq
);

    localparam logic [15:0] ADDR_COLOR = 16'h4000;
    localparam logic [15:0] ADDR_RANGE = 16'h4004;
    localparam logic [15:0] ADDR_CTRL  = 16'h4008;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t        state, state_nxt;

    logic [23:0]   color, color_snap;
    logic [PW-1:0] first, last, last_snap, idx;
    logic          sticky;

    logic          acc_c, wr_c, rd_c;
    logic          pix_sel_c, col_sel_c, rng_sel_c, ctl_sel_c;
    logic          cpu_pix_c, start_c, abort_c, fill_go_c, fill_end_c;
    logic [31:0]   rdat_nxt;
    logic          mem_wr_nxt;
    logic [PW-1:0] mem_addr_nxt;
    logic [23:0]   mem_wdat_nxt;
    logic          unused_c;

    assign unused_c = ^ctrl_wdat;

    // Bus decode; an access takes effect only on its first cycle (done not yet high)
    always_comb begin
        acc_c      = (ctrl_wr | ctrl_rd) & ~ctrl_done;
        wr_c       = acc_c & ctrl_wr;
        rd_c       = acc_c & ~ctrl_wr & ctrl_rd;
        pix_sel_c  = (ctrl_addr[15:14] == 2'b00);
        col_sel_c  = (ctrl_addr == ADDR_COLOR);
        rng_sel_c  = (ctrl_addr == ADDR_RANGE);
        ctl_sel_c  = (ctrl_addr == ADDR_CTRL);
        cpu_pix_c  = wr_c & pix_sel_c;
        abort_c    = wr_c & ctl_sel_c & ctrl_wdat[1];
        start_c    = wr_c & ctl_sel_c & ctrl_wdat[0] & ~ctrl_wdat[1];
        fill_go_c  = (state == FILL) & ~cpu_pix_c & ~abort_c;
        fill_end_c = (state == FILL) & (abort_c | (fill_go_c & (idx == last_snap)));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c) state_nxt = FILL;
            FILL:    if (fill_end_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux and pixel-port arbitration (CPU write beats fill)
    always_comb begin
        rdat_nxt     = '0;
        mem_wr_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        mem_wdat_nxt = mem_wdat;
        if (rd_c) begin
            if (col_sel_c) begin
                rdat_nxt[23:0] = color;
            end else if (rng_sel_c) begin
                rdat_nxt[0 +: PW]  = first;
                rdat_nxt[16 +: PW] = last;
            end else if (ctl_sel_c) begin
                rdat_nxt[0]        = (state == FILL);
                rdat_nxt[1]        = sticky;
                rdat_nxt[16 +: PW] = idx;
            end
        end
        if (cpu_pix_c) begin
            mem_wr_nxt   = 1'b1;
            mem_addr_nxt = PW'(ctrl_addr[15:2]);
            mem_wdat_nxt = ctrl_wdat[23:0];
        end else if (fill_go_c) begin
            mem_wr_nxt   = 1'b1;
            mem_addr_nxt = idx;
            mem_wdat_nxt = color_snap;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_done <= 1'b0;
            ctrl_rdat <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdat  <= '0;
            fill_irq  <= 1'b0;
        end else begin
            ctrl_done <= acc_c;
            ctrl_rdat <= rdat_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdat  <= mem_wdat_nxt;
            fill_irq  <= fill_end_c;
        end
    end

    // Register file, fill snapshot and fill index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            color      <= '0;
            first      <= '0;
            last       <= '0;
            color_snap <= '0;
            last_snap  <= '0;
            idx        <= '0;
            sticky     <= 1'b0;
        end else begin
            if (wr_c && col_sel_c) color <= ctrl_wdat[23:0];
            if (wr_c && rng_sel_c) begin
                first <= ctrl_wdat[0 +: PW];
                last  <= ctrl_wdat[16 +: PW];
            end
            if (state == IDLE && start_c) begin
                idx        <= first;
                color_snap <= color;
                last_snap  <= last;
                sticky     <= 1'b0;
            end else if (fill_go_c) begin
                idx <= idx + PW'(1);
            end
            if (fill_end_c) sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ledpanel_wr_arb.sv
// Self-checking bench for ledpanel_wr_arb: bus tasks, a write monitor, and
// per-scenario checks against expected pixel sequences computed from the range.
module tb_ledpanel_wr_arb;

    localparam int unsigned PW   = 10;
    localparam int          MASK = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ctrl_wr = 1'b0, ctrl_rd = 1'b0;
    logic [15:0]   ctrl_addr = '0;
    logic [31:0]   ctrl_wdat = '0;
    logic [31:0]   ctrl_rdat;
    logic          ctrl_done, mem_wr, fill_irq;
    logic [PW-1:0] mem_addr;
    logic [23:0]   mem_wdat;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        int unsigned   cyc;
        logic [PW-1:0] a;
        logic [23:0]   d;
    } mw_t;

    mw_t         mq[$];
    int unsigned cyc = 0;
    int          irq_cnt = 0;

    ledpanel_wr_arb #(.SIZE(1)) dut (
        .clk(clk), .resetn(resetn),
        .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .fill_irq(fill_irq)
    );

    always #5 clk = ~clk;

    // Record every memory write and irq pulse with the cycle it was registered in
    always @(posedge clk) begin
        mw_t t;
        #1;
        cyc++;
        if (mem_wr === 1'b1) begin
            t.cyc = cyc; t.a = mem_addr; t.d = mem_wdat;
            mq.push_back(t);
        end
        if (fill_irq === 1'b1) irq_cnt++;
    end

    task automatic bus_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int lat, output int unsigned ecyc);
        @(negedge clk);
        ctrl_wr = wr; ctrl_rd = ~wr; ctrl_addr = a; ctrl_wdat = d; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ctrl_done !== 1'b1 && lat < 8);
        rd = ctrl_rdat; ecyc = cyc;
        n_chk++;
        if (ctrl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_timeout addr=%h: ctrl_done not seen within %0d cycles", a, lat);
        end
        ctrl_wr = 1'b0; ctrl_rd = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        logic [31:0] r; int l; int unsigned e;
        bus_xfer(1'b1, a, d, r, l, e);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] r);
        int l; int unsigned e;
        bus_xfer(1'b0, a, 32'h0, r, l, e);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({ctrl_done, ctrl_rdat, mem_wr, mem_addr, mem_wdat, fill_irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b rdat=%h wr=%b addr=%h wdat=%h irq=%b, want all 0",
                     ctrl_done, ctrl_rdat, mem_wr, mem_addr, mem_wdat, fill_irq);
        end
        resetn = 1'b1;
        bus_rd(16'h4008, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", r); end
        bus_rd(16'h4004, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_range: got %h want 0", r); end
    endtask

    task automatic test_pixel_write();
        logic [31:0] r; int lat; int unsigned e; int base;
        base = mq.size();
        bus_xfer(1'b1, 16'h0010, 32'h00FF8040, r, lat, e);
        n_chk++;
        if (lat !== 1) begin n_fail++; $display("FAIL pix_latency: got %0d want 1", lat); end
        repeat (3) @(negedge clk);
        n_chk++;
        if (mq.size() - base !== 1) begin
            n_fail++; $display("FAIL pix_count: got %0d want 1", mq.size() - base);
        end else begin
            n_chk++;
            if (mq[base].a !== 10'd4 || mq[base].d !== 24'hFF8040) begin
                n_fail++;
                $display("FAIL pix_data: got addr=%0d data=%h want 4/ff8040", mq[base].a, mq[base].d);
            end
        end
        bus_rd(16'h0010, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL pix_read: got %h want 0", r); end
        bus_rd(16'h5000, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", r); end
        base = mq.size();
        bus_wr(16'h6000, 32'h00ABCDEF);
        repeat (3) @(negedge clk);
        n_chk++;
        if (mq.size() !== base) begin n_fail++; $display("FAIL unmapped_write: got %0d writes want 0", mq.size() - base); end
    endtask

    // Program and run a fill, optionally with CPU pixel writes racing it, then check
    task automatic run_fill(input string nm, input logic [23:0] col, input int first,
                            input int last, input int ncpu, input int cpu_idx);
        logic [31:0]   r;
        logic [PW-1:0] ca[$];
        logic [23:0]   cd[$];
        int unsigned   ccyc[$];
        int            base, ibase, cnt, nf, errs, cerr, nc, in_span;
        int unsigned   c_first, c_last;
        logic [PW-1:0] a;
        logic [23:0]   d;
        bus_wr(16'h4000, {8'h0, col});
        bus_wr(16'h4004, 32'((last & MASK) << 16) | 32'(first & MASK));
        base = mq.size(); ibase = irq_cnt;
        bus_wr(16'h4008, 32'h1);
        for (int i = 0; i < ncpu; i++) begin
            a = (cpu_idx >= 0) ? PW'(cpu_idx) : PW'($urandom);
            d = col ^ (24'($urandom) | 24'h1);
            ca.push_back(a); cd.push_back(d);
            bus_wr(16'({a, 2'b00}), {8'h0, d});
        end
        cnt = ((last - first) & MASK) + 1;
        for (int k = 0; k < cnt + 60 && irq_cnt == ibase; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        nf = 0; errs = 0; cerr = 0; nc = 0; c_first = 0; c_last = 0; in_span = 0;
        for (int k = base; k < mq.size(); k++) begin
            if (mq[k].d === col) begin
                if (mq[k].a !== PW'(first + nf)) errs++;
                if (nf == 0) c_first = mq[k].cyc;
                c_last = mq[k].cyc;
                nf++;
            end else begin
                if (nc >= ncpu || mq[k].a !== ca[nc] || mq[k].d !== cd[nc]) cerr++;
                ccyc.push_back(mq[k].cyc);
                nc++;
            end
        end
        foreach (ccyc[i]) if (ccyc[i] > c_first && ccyc[i] < c_last) in_span++;
        n_chk++;
        if (irq_cnt - ibase !== 1) begin n_fail++; $display("FAIL %s_irq: got %0d pulses want 1", nm, irq_cnt - ibase); end
        n_chk++;
        if (nf !== cnt) begin n_fail++; $display("FAIL %s_count: got %0d fill writes want %0d", nm, nf, cnt); end
        n_chk++;
        if (errs !== 0) begin n_fail++; $display("FAIL %s_order: %0d fill writes out of sequence from %0d", nm, errs, first); end
        n_chk++;
        if (nc !== ncpu || cerr !== 0) begin
            n_fail++; $display("FAIL %s_cpu: got %0d cpu writes (%0d bad) want %0d", nm, nc, cerr, ncpu);
        end
        n_chk++;
        if (nf > 0 && int'(c_last - c_first) + 1 !== cnt + in_span) begin
            n_fail++;
            $display("FAIL %s_span: fill spanned %0d cycles want %0d", nm, c_last - c_first + 1, cnt + in_span);
        end
        bus_rd(16'h4008, r);
        n_chk++;
        if (r[1:0] !== 2'b10) begin n_fail++; $display("FAIL %s_status: got busy/done=%b want 10", nm, r[1:0]); end
    endtask

    task automatic test_abort();
        logic [31:0] r; int base, ibase, nf, late, errs, lat; int unsigned ecyc;
        bus_wr(16'h4000, 32'h00A5A5A5);
        bus_wr(16'h4004, 32'h00630000);
        base = mq.size(); ibase = irq_cnt;
        bus_wr(16'h4008, 32'h1);
        for (int k = 0; k < 20 && mq.size() - base < 3; k++) @(negedge clk);
        bus_xfer(1'b1, 16'h4008, 32'h2, r, lat, ecyc);
        repeat (5) @(negedge clk);
        nf = 0; late = 0; errs = 0;
        for (int k = base; k < mq.size(); k++) begin
            if (mq[k].cyc >= ecyc) late++;
            if (mq[k].a !== PW'(nf) || mq[k].d !== 24'hA5A5A5) errs++;
            nf++;
        end
        n_chk++;
        if (late !== 0 || errs !== 0) begin
            n_fail++; $display("FAIL abort_stop: %0d writes after abort, %0d wrong", late, errs);
        end
        n_chk++;
        if (nf < 3 || nf >= 100) begin n_fail++; $display("FAIL abort_count: got %0d fill writes want 3..99", nf); end
        n_chk++;
        if (irq_cnt - ibase !== 1) begin n_fail++; $display("FAIL abort_irq: got %0d want 1", irq_cnt - ibase); end
        bus_rd(16'h4008, r);
        n_chk++;
        if (r[1:0] !== 2'b10) begin n_fail++; $display("FAIL abort_status: got %b want 10", r[1:0]); end
        base = mq.size();
        bus_wr(16'h4008, 32'h2);
        repeat (5) @(negedge clk);
        n_chk++;
        if (irq_cnt - ibase !== 1 || mq.size() !== base) begin
            n_fail++; $display("FAIL abort_idle: got irqs=%0d writes=%0d want 1/0", irq_cnt - ibase, mq.size() - base);
        end
        ibase = irq_cnt;
        bus_wr(16'h4008, 32'h3);
        repeat (5) @(negedge clk);
        bus_rd(16'h4008, r);
        n_chk++;
        if (irq_cnt !== ibase || mq.size() !== base || r[0] !== 1'b0) begin
            n_fail++; $display("FAIL start_abort: got irqs=%0d writes=%0d busy=%b want 0/0/0",
                               irq_cnt - ibase, mq.size() - base, r[0]);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] r; logic [23:0] ca, cb; int base, ibase, na, nb, errs;
        ca = 24'($urandom); cb = ca ^ 24'h000001;
        bus_wr(16'h4000, {8'h0, ca});
        bus_wr(16'h4004, 32'h00130000);
        base = mq.size(); ibase = irq_cnt;
        bus_wr(16'h4008, 32'h1);
        bus_wr(16'h4000, {8'h0, cb});
        bus_wr(16'h4004, 32'h00650064);
        bus_wr(16'h4008, 32'h1);
        bus_rd(16'h4008, r);
        n_chk++;
        if (r[1:0] !== 2'b01) begin n_fail++; $display("FAIL busy_status: got %b want 01", r[1:0]); end
        for (int k = 0; k < 60 && irq_cnt == ibase; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        na = 0; nb = 0; errs = 0;
        for (int k = base; k < mq.size(); k++) begin
            if (mq[k].d === ca) begin if (mq[k].a !== PW'(na)) errs++; na++; end
            else nb++;
        end
        n_chk++;
        if (na !== 20 || nb !== 0 || errs !== 0 || irq_cnt - ibase !== 1) begin
            n_fail++; $display("FAIL busy_fill: got old=%0d new=%0d bad=%0d irqs=%0d want 20/0/0/1",
                               na, nb, errs, irq_cnt - ibase);
        end
        base = mq.size();
        bus_wr(16'h4008, 32'h1);
        repeat (8) @(negedge clk);
        n_chk++;
        if (mq.size() - base !== 2 || mq[base].a !== 10'd100 || mq[base].d !== cb ||
            mq[base+1].a !== 10'd101 || mq[base+1].d !== cb) begin
            n_fail++; $display("FAIL busy_next: got %0d writes, want 2 at 100,101 color %h", mq.size() - base, cb);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] r; int base, ibase;
        bus_wr(16'h4000, 32'h00112233);
        bus_wr(16'h4004, 32'h00C70000);
        ibase = irq_cnt;
        bus_wr(16'h4008, 32'h1);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({ctrl_done, ctrl_rdat, mem_wr, mem_addr, mem_wdat, fill_irq} !== '0) begin
            n_fail++; $display("FAIL rst_async: got wr=%b addr=%h wdat=%h irq=%b want 0", mem_wr, mem_addr, mem_wdat, fill_irq);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        base = mq.size();
        repeat (10) @(negedge clk);
        n_chk++;
        if (irq_cnt !== ibase || mq.size() !== base) begin
            n_fail++; $display("FAIL rst_quiet: got irqs=%0d writes=%0d want 0/0", irq_cnt - ibase, mq.size() - base);
        end
        bus_rd(16'h4008, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", r); end
        bus_rd(16'h4000, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL rst_color: got %h want 0", r); end
        run_fill("post_rst", 24'h445566, 10, 13, 0, -1);
    endtask

    task automatic test_random_fills();
        int f, len, nc;
        for (int it = 0; it < 8; it++) begin
            f   = int'($urandom_range(0, MASK));
            len = int'($urandom_range(0, 40));
            nc  = int'($urandom_range(0, 3));
            run_fill("rand", 24'($urandom), f, (f + len) & MASK, nc, -1);
        end
    endtask

    initial begin
        test_reset();
        test_pixel_write();
        run_fill("basic", 24'h123456, 5, 9, 0, -1);
        run_fill("wrap", 24'h654321, 1022, 1, 0, -1);
        run_fill("cpu_race", 24'h0F0F0F, 0, 15, 1, 700);
        test_abort();
        test_busy_writes();
        test_reset_mid_fill();
        test_random_fills();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
